shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller for the ALU shift path. It performs an N-bit logical shift (N = 0–7) by iterating the single-bit ALU shift. Each pass is routed through the ShiftALUMux: pass 1 takes the register operand (mux input Source1), later passes take the sequencer's working register (mux input Source2). It drives the mux select, the shift direction, a pipeline stall and the final write-back strobe. It sits between the decoder (Start/Amount/Dir) and the ALU/register-file write port.

## Interface
- WIDTH, 8, datapath width
- CNT_W, 3, shift-amount width; max shift 2^CNT_W−1
- CLK  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  shift request from decoder; sampled only in IDLE
- Dir  input  1  0 = left, 1 = right (logical, zero fill)
- Amount  input  CNT_W  shift count
- MuxOut  input  WIDTH  current ShiftALUMux output
- AluOut  input  WIDTH  ALU result (MuxOut shifted by 1 in ShiftDir)
- Shift  output  1  mux select: 0 = Source1, 1 = Source2
- ShiftDir  output  1  direction to ALU
- SeqOperand  output  WIDTH  working register; wired to mux Source2
- Stall  output  1  freeze PC/fetch
- Done  output  1  one-cycle completion pulse
- RegWrite  output  1  write SeqOperand to destination; equals Done

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - Shift=0.
  - ShiftDir = Dir (combinational).
  - Stall = Start.
- **Start in IDLE with Amount=0:**
  - SeqOperand <= MuxOut (pass-through).
  - → DONE.
- **Start in IDLE with Amount=1:**
  - SeqOperand <= AluOut.
  - → DONE.
- **Start in IDLE with Amount≥2:**
  - SeqOperand <= AluOut.
  - Count <= Amount−1.
  - DirReg <= Dir.
  - → RUN.
- **RUN:**
  - Shift=1, Stall=1.
  - ShiftDir = DirReg.
  - Each cycle: SeqOperand <= AluOut and Count <= Count−1.
  - When Count==1 → DONE.
- **DONE:**
  - Done=1, RegWrite=1, Stall=0, Shift=0.
  - SeqOperand holds the result.
  - → IDLE unconditionally.
- Start is ignored in RUN and DONE; no queuing.
- Count never wraps: the RUN exit fires at Count==1, and Count is never loaded with 0 in RUN.
- Arithmetic: bits shifted out are discarded; no carry/flag output.
- **Reset (any state, asynchronous):**
  - State=IDLE, SeqOperand=0, Count=0, DirReg=0.
  - All outputs 0 except ShiftDir, which follows Dir.
  - Any in-flight shift is abandoned with no RegWrite.

## Timing
- Start accepted at cycle 0. Done/RegWrite asserted in cycle max(Amount,1), lasting exactly one cycle.
- Stall is high in cycles 0 … max(Amount,1)−1 and low in the Done cycle, so the instruction retires with Done.
- Shift is 0 in cycle 0 and 1 in cycles 1 … Amount−1.
- Back-to-back: a Start in the cycle after Done is accepted (the state is IDLE by then).

## Configuration
- SHIFT_SEQ_EARLY_EXIT_EN
- **Defined:**
  - A pass whose AluOut==0 (cycle 0 or RUN) loads SeqOperand=0 and goes directly to DONE, regardless of remaining Count.
  - Latency becomes min(passes until zero, Amount).
- **Undefined:**
  - Always exactly max(Amount,1) cycles.
  - No zero detect is synthesized.

## Structure
- Package ShiftSeqPkg:
  - state enum {IDLE, RUN, DONE}
  - WIDTH_DEF=8, CNT_W_DEF=3
  - SEL_SOURCE1=1'b0, SEL_SOURCE2=1'b1
- Sub-module ShiftSeqCounter:
  - Loadable CNT_W down-counter with load, decrement and is_one outputs.
  - Async active-low clear.
- The bench models the ALU as a 1-bit logical shift of a ShiftALUMux instance output.

## Test plan
- Operand 0x96, Dir=0, Amount=3 → Shift sequence 0,1,1; Done at cycle 3; SeqOperand=0xB0; RegWrite one cycle.
- Operand 0x81, Dir=1, Amount=2 → Done at cycle 2; SeqOperand=0x20; Stall high cycles 0–1 only.
- Operand 0x5A, Amount=0 → Shift=0 throughout; Done at cycle 1; SeqOperand=0x5A.
- Start pulsed again in cycle 1 of an Amount=5 shift → ignored; single Done at cycle 5; the next Start the cycle after Done is accepted.
- Reset_n low in cycle 2 of an Amount=6 shift → all outputs 0 immediately; no Done/RegWrite; state returns to IDLE.
- Operand 0x80, Dir=0, Amount=7 → with SHIFT_SEQ_EARLY_EXIT_EN, Done at cycle 1 and SeqOperand=0x00; without it, Done at cycle 7 and SeqOperand=0x00.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Holds the FSM state encoding, default sizes and ShiftALUMux select values.
package ShiftSeqPkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  localparam logic SEL_SOURCE1 = 1'b0;
  localparam logic SEL_SOURCE2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Decoder / ShiftALUMux / ALU side signals of the shift sequencer.
// The slave modport is the sequencer; master is the surrounding datapath.
interface shift_sequencer_if
  import ShiftSeqPkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             Start;
  logic             Dir;
  logic [CNT_W-1:0] Amount;
  logic [WIDTH-1:0] MuxOut;
  logic [WIDTH-1:0] AluOut;
  logic             Shift;
  logic             ShiftDir;
  logic [WIDTH-1:0] SeqOperand;
  logic             Stall;
  logic             Done;
  logic             RegWrite;

  modport master (
    output Start, Dir, Amount, MuxOut, AluOut,
    input  Shift, ShiftDir, SeqOperand, Stall, Done, RegWrite
  );

  modport slave (
    input  Start, Dir, Amount, MuxOut, AluOut,
    output Shift, ShiftDir, SeqOperand, Stall, Done, RegWrite
  );

endinterface

// File: rtl/shift_sequencer_counter.sv
// Loadable down-counter tracking the remaining shift passes.
// Saturates at zero so it can never wrap back to the maximum count.
module ShiftSeqCounter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             decrement,
  input  logic [CNT_W-1:0] load_value,
  output logic             is_one
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle N-bit logical shift controller driving the ShiftALUMux and ALU.
// Optional SHIFT_SEQ_EARLY_EXIT_EN: finish as soon as a pass produces zero.
module shift_sequencer
  import ShiftSeqPkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             CLK,
  input logic             Reset_n,
  shift_sequencer_if.slave bus
);

  state_t           state, state_next;
  logic [WIDTH-1:0] seq_operand, seq_operand_next;
  logic             dir_reg, dir_reg_next;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_value;
  logic             alu_zero;
  logic             shift_sel, shift_dir, stall, done_pulse;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  assign alu_zero = (bus.AluOut == '0);
`else
  assign alu_zero = 1'b0;
`endif

  assign cnt_value = bus.Amount - CNT_W'(1);

  ShiftSeqCounter #(.CNT_W(CNT_W)) u_counter (
    .clk        (CLK),
    .rst_n      (Reset_n),
    .load       (cnt_load),
    .decrement  (cnt_dec),
    .load_value (cnt_value),
    .is_one     (cnt_is_one)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      seq_operand <= '0;
      dir_reg     <= 1'b0;
    end else begin
      state       <= state_next;
      seq_operand <= seq_operand_next;
      dir_reg     <= dir_reg_next;
    end
  end

  // Pass 1 happens in the accepting IDLE cycle; RUN covers the remaining passes.
  always_comb begin
    state_next       = state;
    seq_operand_next = seq_operand;
    dir_reg_next     = dir_reg;
    cnt_load         = 1'b0;
    cnt_dec          = 1'b0;
    shift_sel        = SEL_SOURCE1;
    shift_dir        = bus.Dir;
    stall            = 1'b0;
    done_pulse       = 1'b0;
    case (state)
      IDLE: begin
        stall = bus.Start;
        if (bus.Start) begin
          if (bus.Amount == '0) begin
            seq_operand_next = bus.MuxOut;
            state_next       = DONE;
          end else begin
            seq_operand_next = bus.AluOut;
            if ((bus.Amount == CNT_W'(1)) || alu_zero) begin
              state_next = DONE;
            end else begin
              cnt_load     = 1'b1;
              dir_reg_next = bus.Dir;
              state_next   = RUN;
            end
          end
        end
      end
      RUN: begin
        shift_sel        = SEL_SOURCE2;
        stall            = 1'b1;
        shift_dir        = dir_reg;
        seq_operand_next = bus.AluOut;
        cnt_dec          = 1'b1;
        if (cnt_is_one || alu_zero) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_pulse = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stall is masked by reset so every output except ShiftDir reads 0 while held in reset.
  assign bus.Shift      = shift_sel;
  assign bus.ShiftDir   = shift_dir;
  assign bus.SeqOperand = seq_operand;
  assign bus.Stall      = stall & Reset_n;
  assign bus.Done       = done_pulse;
  assign bus.RegWrite   = done_pulse;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: per-cycle model compare plus directed literal checks.
// The ShiftALUMux and 1-bit ALU are modelled with continuous assigns around the DUT.
module tb_shift_sequencer;

  logic       CLK;
  logic       Reset_n;
  logic [7:0] operand;

  int checks;
  int errors;

  shift_sequencer_if #(.WIDTH(8), .CNT_W(3)) bus ();

  assign bus.MuxOut = bus.Shift ? bus.SeqOperand : operand;
  assign bus.AluOut = bus.ShiftDir ? (bus.MuxOut >> 1) : (bus.MuxOut << 1);

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] shiftBy(input logic [7:0] v, input logic d, input int n);
    logic [7:0] r;
    r = d ? (v >> n) : (v << n);
    return r;
  endfunction

  // Cycles from acceptance to Done: the number of passes actually performed.
  function automatic int expLatency(input logic [7:0] v, input logic d, input int amt);
    if (amt == 0) return 1;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    for (int k = 1; k <= amt; k++) begin
      if (shiftBy(v, d, k) == 8'h00) return k;
    end
`endif
    return amt;
  endfunction

  // Behavioural model: one in-flight transaction, checked every cycle.
  bit         active = 1'b0;
  int         cyc;
  int         lat;
  logic [7:0] mOp;
  logic       mDir;
  logic [7:0] mRes;
  logic [7:0] lastResult = 8'h00;

  always @(negedge CLK) begin
    if (!Reset_n) begin
      checkOutput("rstStall", bus.Stall, 0);
      checkOutput("rstShift", bus.Shift, 0);
      checkOutput("rstDone", bus.Done, 0);
      checkOutput("rstRegWrite", bus.RegWrite, 0);
      checkOutput("rstSeqOperand", bus.SeqOperand, 0);
      checkOutput("rstShiftDir", bus.ShiftDir, bus.Dir);
      active     = 1'b0;
      lastResult = 8'h00;
    end else if (!active) begin
      checkOutput("idleStall", bus.Stall, bus.Start);
      checkOutput("idleShift", bus.Shift, 0);
      checkOutput("idleDone", bus.Done, 0);
      checkOutput("idleRegWrite", bus.RegWrite, 0);
      checkOutput("idleShiftDir", bus.ShiftDir, bus.Dir);
      checkOutput("idleSeqOperand", bus.SeqOperand, lastResult);
      if (bus.Start) begin
        active = 1'b1;
        cyc    = 0;
        mOp    = operand;
        mDir   = bus.Dir;
        lat    = expLatency(operand, bus.Dir, int'(bus.Amount));
        mRes   = (bus.Amount == 3'd0) ? operand : shiftBy(operand, bus.Dir, int'(bus.Amount));
      end
    end else begin
      cyc++;
      checkOutput("runStall", bus.Stall, cyc < lat);
      checkOutput("runShift", bus.Shift, cyc < lat);
      checkOutput("runDone", bus.Done, cyc == lat);
      checkOutput("runRegWrite", bus.RegWrite, cyc == lat);
      if (cyc < lat) begin
        checkOutput("runShiftDir", bus.ShiftDir, mDir);
        checkOutput("runSeqOperand", bus.SeqOperand, shiftBy(mOp, mDir, cyc));
      end else begin
        checkOutput("doneSeqOperand", bus.SeqOperand, mRes);
        lastResult = mRes;
        active     = 1'b0;
      end
    end
  end

  int         doneCycle;
  logic [7:0] result;
  logic [7:0] shiftSeq;
  int         stallCycles;

  // Runs one shift; returns in the cycle after Done with Start low.
  task automatic applyStimulus(input logic [7:0] op, input logic dir, input logic [2:0] amt, input int pulseCycle);
    operand     = op;
    bus.Dir     = dir;
    bus.Amount  = amt;
    bus.Start   = 1'b1;
    doneCycle   = -1;
    result      = 8'h00;
    shiftSeq    = 8'h00;
    stallCycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (c < 8) shiftSeq[c] = bus.Shift;
      if (bus.Stall) stallCycles++;
      if (bus.Done) begin
        doneCycle = c;
        result    = bus.SeqOperand;
      end
      @(posedge CLK);
      #1;
      bus.Start = (c + 1 == pulseCycle);
      if (c == 0) bus.Dir = ~dir;
      if (doneCycle >= 0) break;
    end
    bus.Start = 1'b0;
  endtask

  int doneSeen;

  initial begin
    checks     = 0;
    errors     = 0;
    Reset_n    = 1'b0;
    operand    = 8'h00;
    bus.Start  = 1'b0;
    bus.Dir    = 1'b0;
    bus.Amount = 3'd0;
    #2;
    checkOutput("resetSeqOperand", bus.SeqOperand, 8'h00);
    checkOutput("resetDone", bus.Done, 0);
    checkOutput("resetStall", bus.Stall, 0);
    repeat (3) @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;

    applyStimulus(8'h96, 1'b0, 3'd3, -1);
    checkOutput("t1DoneCycle", doneCycle, 3);
    checkOutput("t1Result", result, 8'hB0);
    checkOutput("t1ShiftSeq", shiftSeq, 8'h06);

    applyStimulus(8'h81, 1'b1, 3'd2, -1);
    checkOutput("t2DoneCycle", doneCycle, 2);
    checkOutput("t2Result", result, 8'h20);
    checkOutput("t2StallCycles", stallCycles, 2);

    applyStimulus(8'h5A, 1'b0, 3'd0, -1);
    checkOutput("t3DoneCycle", doneCycle, 1);
    checkOutput("t3Result", result, 8'h5A);
    checkOutput("t3ShiftSeq", shiftSeq, 8'h00);

    applyStimulus(8'h33, 1'b0, 3'd5, 1);
    checkOutput("t4DoneCycle", doneCycle, 5);
    checkOutput("t4Result", result, 8'h60);
    applyStimulus(8'h0F, 1'b1, 3'd1, -1);
    checkOutput("t4BackToBackDone", doneCycle, 1);
    checkOutput("t4BackToBackResult", result, 8'h07);

    operand    = 8'h3C;
    bus.Dir    = 1'b0;
    bus.Amount = 3'd6;
    bus.Start  = 1'b1;
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
    @(posedge CLK);
    #1;
    Reset_n = 1'b0;
    #1;
    checkOutput("t5Stall", bus.Stall, 0);
    checkOutput("t5Shift", bus.Shift, 0);
    checkOutput("t5Done", bus.Done, 0);
    checkOutput("t5SeqOperand", bus.SeqOperand, 8'h00);
    repeat (2) @(posedge CLK);
    #1;
    Reset_n  = 1'b1;
    doneSeen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.Done || bus.RegWrite) doneSeen++;
    end
    checkOutput("t5NoDoneAfterReset", doneSeen, 0);
    @(posedge CLK);
    #1;

    applyStimulus(8'hC3, 1'b1, 3'd4, -1);
    checkOutput("t6DoneCycle", doneCycle, 4);
    checkOutput("t6Result", result, 8'h0C);

    applyStimulus(8'h80, 1'b0, 3'd7, -1);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    checkOutput("t7DoneCycle", doneCycle, 1);
`else
    checkOutput("t7DoneCycle", doneCycle, 7);
`endif
    checkOutput("t7Result", result, 8'h00);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
